play_ctrl_mcu: RTL

PLAY_CTRL_MCU -- requirements
Module: play_ctrl_mcu

---
 rtl/play_ctrl_mcu_pkg.sv | 21 ++
 rtl/play_ctrl_mcu_dffr.sv | 19 +
 rtl/play_ctrl_mcu.sv | 90 +++++++++
 3 files changed

// File: rtl/play_ctrl_mcu_pkg.sv
// Shared encodings for the playback controller, also used by the display logic.
package play_ctrl_mcu_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] mode_t;

  localparam state_t StIdle  = 2'b00;
  localparam state_t StLoad  = 2'b01;
  localparam state_t StPlay  = 2'b10;
  localparam state_t StPause = 2'b11;

  localparam mode_t ModeSingle  = 2'b00;
  localparam mode_t ModeRepeat  = 2'b01;
  localparam mode_t ModeAdvance = 2'b10;

  // Mode 11 is reserved and behaves like single.
  function automatic logic is_stop_mode(input mode_t m);
    return !((m == ModeRepeat) || (m == ModeAdvance));
  endfunction

endpackage

// File: rtl/play_ctrl_mcu_dffr.sv
// Resettable D flip-flop bank: asynchronous active-high reset to zero.
module play_ctrl_mcu_dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/play_ctrl_mcu.sv
// Song playback controller: selects, loads, plays, pauses and sequences songs for a note player.
module play_ctrl_mcu
  import play_ctrl_mcu_pkg::*;
#(
  parameter int unsigned NUM_SONGS = 16,
  parameter int unsigned SONG_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SONG_W-1:0] song_input,
  input  logic              song_valid,
  input  logic              pause_btn,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        state
);

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              done_stop_q, done_stop_d;
  logic              sel_ok;
  logic [SONG_W-1:0] song_next;

  // Out-of-range selections are dropped as if the strobe never happened.
  assign sel_ok    = song_valid && (32'(song_input) < NUM_SONGS);
  assign song_next = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    done_stop_d = 1'b0;
    if (sel_ok) begin
      state_d = StLoad;
      song_d  = song_input;
    end else begin
      unique case (state_q)
        StLoad:  state_d = StPlay;
        StPlay: begin
          if (song_done) begin
            if (is_stop_mode(mode)) begin
              state_d     = StIdle;
              done_stop_d = 1'b1;
            end else begin
              state_d = StLoad;
              if (mode == ModeAdvance) begin
                song_d = song_next;
              end
            end
          end else if (pause_btn) begin
            state_d = StPause;
          end
        end
        StPause: if (pause_btn) state_d = StPlay;
        StIdle:  if (pause_btn) state_d = StLoad;
        default: state_d = StIdle;
      endcase
    end
  end

  play_ctrl_mcu_dffr #(.WIDTH(2)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_d),
    .q     (state_q)
  );

  play_ctrl_mcu_dffr #(.WIDTH(SONG_W)) u_song_reg (
    .clk   (clk),
    .reset (reset),
    .d     (song_d),
    .q     (song_q)
  );

  // Extends the player clear by one cycle after a song ends into IDLE.
  play_ctrl_mcu_dffr #(.WIDTH(1)) u_done_stop_reg (
    .clk   (clk),
    .reset (reset),
    .d     (done_stop_d),
    .q     (done_stop_q)
  );

  assign play         = (state_q == StPlay);
  assign reset_player = (state_q == StLoad) || done_stop_q;
  assign song         = song_q;
  assign state        = state_q;

endmodule
